// File: rtl/bit_pattern_generator.sv
// bit_pattern_generator: builds an LSB-aligned thermometer word holding count_in ones,
// shifting in one '1' per cycle under an s/done start handshake.
module bit_pattern_generator #(
    parameter int A_WIDTH   = 8,
    parameter int RET_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s,
    input  logic [RET_WIDTH-1:0] count_in,
    output logic [A_WIDTH-1:0]   A,
    output logic                 busy,
    output logic                 done,
    output logic                 sat
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;
    localparam logic [RET_WIDTH-1:0] MAX_COUNT = RET_WIDTH'(A_WIDTH);
    logic [1:0]           state;
    logic [RET_WIDTH-1:0] remaining;
    logic                 over;
    assign over = count_in > MAX_COUNT;
    assign busy = state == SHIFT;
    assign done = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            A         <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) state <= SHIFT;
                    else begin
                        A         <= '0;
                        remaining <= over ? MAX_COUNT : count_in;
                        sat       <= over;
                    end
                end
                SHIFT: begin
                    // the !=0 guard keeps remaining from wrapping below zero
                    if (remaining != '0) begin
                        A         <= A_WIDTH'({A, 1'b1});
                        remaining <= remaining - 1'b1;
                    end else state <= DONE;
                end
                DONE: if (!s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
